// File: rtl/servant_sram_arbiter.sv
// Shares one byte-wide async SRAM between a 32-bit Wishbone port and a byte loader port.
// Latency: ack 1 + N*(WAIT_CYCLES+2) clocks after grant (N = selected bytes); one request in flight.
// Backpressure: requests are held until ack; SERVANT_SRAM_ARB_RR_EN selects round-robin over fixed B priority.
module servant_sram_arbiter #(
  parameter int ADDRESS_WIDTH = 18,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  input  logic [ADDRESS_WIDTH-3:0] wb_adr,
  input  logic [31:0]              wb_dat,
  input  logic [3:0]               wb_sel,
  input  logic                     wb_we,
  input  logic                     wb_cyc,
  output logic [31:0]              wb_rdt,
  output logic                     wb_ack,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_adr,
  input  logic [7:0]               b_wdat,
  output logic [7:0]               b_rdat,
  output logic                     b_ack,
  output logic [ADDRESS_WIDTH-1:0] sAddress,
  output logic                     sCSn,
  output logic                     sOEn,
  output logic                     sWRn,
  output logic                     sDqDir,
  output logic [7:0]               sDqOut,
  input  logic [7:0]               sDqIn
);

  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = (WC > 1) ? $clog2(WC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t                   state_q;
  logic [1:0]               lane_q;
  logic [3:0]               rem_q;
  logic [CW-1:0]            cnt_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              dat_q;
  logic                     we_q;
  logic                     port_b_q;
  logic [31:0]              rd_buf_q;
  logic [ADDRESS_WIDTH-1:0] saddr_q;
  logic                     cs_n_q, oe_n_q, wr_n_q, dq_dir_q;
  logic [7:0]               dq_out_q;
  logic                     wb_ack_q, b_ack_q;
  logic [31:0]              wb_rdt_q;
  logic [7:0]               b_rdat_q;

  logic                     req_any, grant_b;
  logic                     src_b, we_d;
  logic [3:0]               src_sel, rem_d;
  logic [ADDRESS_WIDTH-1:0] src_adr, addr_d;
  logic [31:0]              src_dat;
  logic [1:0]               lane_d;
  logic [7:0]               wdat_d;

  function automatic logic [1:0] first_lane(input logic [3:0] s);
    if (s[0])      return 2'd0;
    else if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign req_any = b_req | wb_cyc;

`ifdef SERVANT_SRAM_ARB_RR_EN
  // Pointer remembers who was granted last; reset value points at Wishbone.
  logic last_b_q;
  assign grant_b = b_req & (~wb_cyc | ~last_b_q);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      last_b_q <= 1'b0;
    end else if (state_q == IDLE && req_any) begin
      last_b_q <= grant_b;
    end
  end
`else
  assign grant_b = b_req;
`endif

  // In IDLE the next lane comes from the requester being granted; later from the latched copy.
  always_comb begin
    src_b   = port_b_q;
    we_d    = we_q;
    src_sel = rem_q;
    src_adr = addr_q;
    src_dat = dat_q;
    if (state_q == IDLE) begin
      src_b   = grant_b;
      we_d    = grant_b ? b_we : wb_we;
      src_sel = grant_b ? 4'b0001 : wb_sel;
      src_adr = grant_b ? b_adr : {wb_adr, 2'b00};
      src_dat = grant_b ? {24'h0, b_wdat} : wb_dat;
    end
    lane_d = first_lane(src_sel);
    rem_d  = src_sel & ~(4'b0001 << lane_d);
    addr_d = src_b ? src_adr : {src_adr[ADDRESS_WIDTH-1:2], lane_d};
    wdat_d = src_dat[{lane_d, 3'b000} +: 8];
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      lane_q   <= 2'd0;
      rem_q    <= 4'd0;
      cnt_q    <= '0;
      addr_q   <= '0;
      dat_q    <= 32'h0;
      we_q     <= 1'b0;
      port_b_q <= 1'b0;
      rd_buf_q <= 32'h0;
      saddr_q  <= '0;
      cs_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      dq_dir_q <= 1'b0;
      dq_out_q <= 8'h0;
      wb_ack_q <= 1'b0;
      b_ack_q  <= 1'b0;
      wb_rdt_q <= 32'h0;
      b_rdat_q <= 8'h0;
    end else begin
      wb_ack_q <= 1'b0;
      b_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            port_b_q <= grant_b;
            we_q     <= we_d;
            addr_q   <= src_adr;
            dat_q    <= src_dat;
            rd_buf_q <= 32'h0;
            if (src_sel == 4'b0000) begin
              wb_rdt_q <= 32'h0;
              wb_ack_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              lane_q   <= lane_d;
              rem_q    <= rem_d;
              saddr_q  <= addr_d;
              cs_n_q   <= 1'b0;
              dq_dir_q <= we_d;
              dq_out_q <= we_d ? wdat_d : 8'h0;
              state_q  <= SETUP;
            end
          end
        end
        SETUP: begin
          cnt_q   <= CW'(WC - 1);
          oe_n_q  <= we_q;
          wr_n_q  <= ~we_q;
          state_q <= STROBE;
        end
        STROBE: begin
          if (cnt_q == '0) begin
            oe_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            if (!we_q) rd_buf_q[{lane_q, 3'b000} +: 8] <= sDqIn;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (rem_q != 4'b0000) begin
            lane_q   <= lane_d;
            rem_q    <= rem_d;
            saddr_q  <= addr_d;
            dq_out_q <= we_q ? wdat_d : 8'h0;
            state_q  <= SETUP;
          end else begin
            cs_n_q   <= 1'b1;
            dq_dir_q <= 1'b0;
            state_q  <= DONE;
            if (port_b_q) begin
              b_ack_q  <= 1'b1;
              b_rdat_q <= rd_buf_q[7:0];
            end else begin
              wb_ack_q <= 1'b1;
              wb_rdt_q <= rd_buf_q;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sAddress = saddr_q;
  assign sCSn     = cs_n_q;
  assign sOEn     = oe_n_q;
  assign sWRn     = wr_n_q;
  assign sDqDir   = dq_dir_q;
  assign sDqOut   = dq_out_q;
  assign wb_ack   = wb_ack_q;
  assign b_ack    = b_ack_q;
  assign wb_rdt   = wb_rdt_q;
  assign b_rdat   = b_rdat_q;

endmodule

// File: tb/tb_servant_sram_arbiter.sv
// Directed bench for servant_sram_arbiter with a byte SRAM model and pin monitor.
module tb_servant_sram_arbiter;
  localparam int AW = 18;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n;
  logic [AW-3:0] wb_adr;
  logic [31:0]   wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc;
  logic [31:0]   wb_rdt;
  logic          wb_ack;
  logic          b_req, b_we;
  logic [AW-1:0] b_adr;
  logic [7:0]    b_wdat, b_rdat;
  logic          b_ack;
  logic [AW-1:0] sAddress;
  logic          sCSn, sOEn, sWRn, sDqDir;
  logic [7:0]    sDqOut, sDqIn;

  servant_sram_arbiter dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_rdt(wb_rdt), .wb_ack(wb_ack),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdat(b_wdat), .b_rdat(b_rdat), .b_ack(b_ack),
    .sAddress(sAddress), .sCSn(sCSn), .sOEn(sOEn), .sWRn(sWRn),
    .sDqDir(sDqDir), .sDqOut(sDqOut), .sDqIn(sDqIn)
  );

  always #5 wb_clk = ~wb_clk;

  logic [7:0] mem [0:1023];
  assign sDqIn = (!sCSn && !sOEn) ? mem[sAddress[9:0]] : 8'h00;
  always @(posedge wb_clk) if (!sCSn && !sWRn) mem[sAddress[9:0]] <= sDqOut;

  int cs_low = 0, wr_low = 0, oe_low = 0, dir_on = 0, viol = 0, wb_acks = 0, b_acks = 0;
  logic [25:0] wlog[$];
  logic [17:0] rlog[$];
  logic prev_wr = 1'b1, prev_oe = 1'b1;

  always @(negedge wb_clk) begin
    if (!sCSn) cs_low++;
    if (!sWRn) wr_low++;
    if (!sOEn) oe_low++;
    if (!sCSn && sDqDir) dir_on++;
    if (sDqDir && !sOEn) viol++;
    if (!sOEn && !sWRn) viol++;
    if (!sWRn && prev_wr) wlog.push_back({sAddress, sDqOut});
    if (!sOEn && prev_oe) rlog.push_back(sAddress);
    prev_wr = sWRn;
    prev_oe = sOEn;
    if (wb_ack) wb_acks++;
    if (b_ack) b_acks++;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_txn(input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, output int lat, output logic [31:0] rdt);
    repeat (2) @(negedge wb_clk);
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1;
    lat = -1; rdt = 32'h0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge wb_clk); #1;
      if (wb_ack) begin lat = i; rdt = wb_rdt; break; end
    end
    wb_cyc = 1'b0;
  endtask

  task automatic b_txn(input logic [AW-1:0] adr, input logic [7:0] dat, input logic we,
                       output int lat, output logic [7:0] rd);
    repeat (2) @(negedge wb_clk);
    b_adr = adr; b_wdat = dat; b_we = we; b_req = 1'b1;
    lat = -1; rd = 8'h0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge wb_clk); #1;
      if (b_ack) begin lat = i; rd = b_rdat; break; end
    end
    b_req = 1'b0;
  endtask

  // Both ports raise a read in the same IDLE cycle; report who finished first.
  task automatic both_round(output logic first_b, output int n_acks);
    repeat (2) @(negedge wb_clk);
    b_adr = 18'h20010; b_we = 1'b0; b_req = 1'b1;
    wb_adr = 16'h100; wb_sel = 4'b0001; wb_we = 1'b0; wb_cyc = 1'b1;
    n_acks = 0; first_b = 1'b0;
    for (int i = 0; i < 100 && (b_req || wb_cyc); i++) begin
      @(posedge wb_clk); #1;
      if (b_ack) begin
        if (n_acks == 0) first_b = 1'b1;
        n_acks++;
        b_req = 1'b0;
      end
      if (wb_ack) begin
        n_acks++;
        wb_cyc = 1'b0;
      end
    end
    b_req = 1'b0; wb_cyc = 1'b0;
  endtask

`ifdef SERVANT_SRAM_ARB_RR_EN
  localparam logic R3_FIRST_B = 1'b0;
`else
  localparam logic R3_FIRST_B = 1'b1;
`endif

  initial begin
    int lat, s_cs, s_wr, s_oe, s_dir, s_w, s_r, s_acks, n;
    logic [31:0] rdt, wd;
    logic [7:0]  rd;
    logic [25:0] e;
    logic        found, fb;

    wb_rst_n = 1'b0;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_adr = '0; b_wdat = '0;
    repeat (3) @(negedge wb_clk);
    chk("rst_strobes", {sCSn, sOEn, sWRn, sDqDir}, 4'b1110);
    wb_rst_n = 1'b1;
    repeat (6) @(negedge wb_clk);
    chk("idle_strobes", {sCSn, sOEn, sWRn, sDqDir}, 4'b1110);
    chk("idle_addr_dq", {sAddress, sDqOut}, 0);
    chk("idle_acks", wb_acks + b_acks, 0);
    chk("idle_rdata", {wb_rdt, b_rdat}, 0);

    // Full-word write: four byte cycles, lanes ascending.
    wd = 32'hA1B2C3D4;
    s_cs = cs_low; s_wr = wr_low; s_dir = dir_on; s_w = wlog.size();
    wb_txn(16'h100, wd, 4'b1111, 1'b1, lat, rdt);
    chk("wr_latency", lat, 17);
    chk("wr_bytes", wlog.size() - s_w, 4);
    for (int i = 0; i < 4; i++) begin
      e = {18'h400 + 18'(i), wd[8*i +: 8]};
      if (s_w + i < wlog.size()) chk("wr_addr_data", wlog[s_w + i], e);
    end
    chk("wr_wrn_low_cycles", wr_low - s_wr, 8);
    chk("wr_csn_low_cycles", cs_low - s_cs, 16);
    chk("wr_dqdir_cycles", dir_on - s_dir, 16);

    // Sparse read: lanes 0 and 2 only.
    s_cs = cs_low; s_oe = oe_low; s_r = rlog.size();
    wb_txn(16'h100, 32'h0, 4'b0101, 1'b0, lat, rdt);
    chk("rd_latency", lat, 9);
    chk("rd_data", rdt, 32'h00B200D4);
    chk("rd_accesses", rlog.size() - s_r, 2);
    if (rlog.size() - s_r >= 2) begin
      chk("rd_addr0", rlog[s_r], 18'h400);
      chk("rd_addr1", rlog[s_r + 1], 18'h402);
    end
    chk("rd_oen_low_cycles", oe_low - s_oe, 4);
    chk("rd_csn_low_cycles", cs_low - s_cs, 8);

    // Loader port write then read-back.
    s_w = wlog.size();
    b_txn(18'h20010, 8'h5A, 1'b1, lat, rd);
    chk("b_wr_latency", lat, 5);
    if (wlog.size() > s_w) chk("b_wr_addr_data", wlog[s_w], {18'h20010, 8'h5A});
    else chk("b_wr_addr_data", 0, {18'h20010, 8'h5A});
    b_txn(18'h20010, 8'h00, 1'b0, lat, rd);
    chk("b_rd_latency", lat, 5);
    chk("b_rd_data", rd, 8'h5A);

    // Empty byte-select: immediate ack, no chip select.
    s_cs = cs_low;
    wb_txn(16'h100, 32'h0, 4'b0000, 1'b0, lat, rdt);
    chk("sel0_latency", lat, 1);
    chk("sel0_no_cs", cs_low - s_cs, 0);
    chk("b_rdat_held", b_rdat, 8'h5A);

    // Reset while the write strobe is low.
    repeat (2) @(negedge wb_clk);
    wb_adr = 16'h101; wb_dat = 32'h77; wb_sel = 4'b0001; wb_we = 1'b1; wb_cyc = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge wb_clk); #1;
      if (!sWRn) begin found = 1'b1; break; end
    end
    chk("rst_reach_strobe", found, 1'b1);
    s_acks = wb_acks + b_acks;
    #1 wb_rst_n = 1'b0;
    #1 chk("rst_async_strobes", {sCSn, sOEn, sWRn, sDqDir}, 4'b1110);
    wb_cyc = 1'b0;
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    repeat (2) @(negedge wb_clk);
    chk("rst_no_ack", wb_acks + b_acks - s_acks, 0);
    wb_txn(16'h100, 32'h0, 4'b0001, 1'b0, lat, rdt);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_data", rdt, 32'h000000D4);

    // Contention rounds.
    both_round(fb, n);
    chk("arb1_first_b", fb, 1'b1);
    chk("arb1_acks", n, 2);
    both_round(fb, n);
    chk("arb2_first_b", fb, 1'b1);
    chk("arb2_acks", n, 2);
    b_txn(18'h20010, 8'h00, 1'b0, lat, rd);
    both_round(fb, n);
    chk("arb3_first_b", fb, R3_FIRST_B);
    chk("arb3_acks", n, 2);

    chk("strobe_invariants", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
